// File: rtl/vector_seq_pkg.sv
// rtl/vector_seq_pkg.sv - shared state encoding, vector source codes and default vector addresses
package vector_seq_pkg;

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_LOAD     = 3'd4
    } state_t;

    localparam logic [1:0] VSRC_RST = 2'd0;
    localparam logic [1:0] VSRC_NMI = 2'd1;
    localparam logic [1:0] VSRC_IRQ = 2'd2;
    localparam logic [1:0] VSRC_BRK = 2'd3;

    localparam logic [15:0] DEF_RST_VEC  = 16'hFFFC;
    localparam logic [15:0] DEF_NMI_VEC  = 16'hFFFA;
    localparam logic [15:0] DEF_IRQ_VEC  = 16'hFFFE;
    localparam logic [15:0] DEF_FALLBACK = 16'hFFCA;

endpackage

// File: rtl/nmi_edge_latch.sv
// rtl/nmi_edge_latch.sv - rising-edge NMI detector with pending latch
// o_pend includes the live edge so a fresh NMI competes in the same cycle it is seen.
module nmi_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic i_nmi_req,
    input  logic i_ack,
    output logic o_pend
);

    logic r_nmi_q;
    logic r_pend;
    logic w_edge;

    assign w_edge = i_nmi_req & ~r_nmi_q;
    assign o_pend = r_pend | w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_q <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_nmi_q <= i_nmi_req;
            // A new edge survives an ack unless that ack is consuming this very edge.
            if (w_edge && !(i_ack && !r_pend)) begin
                r_pend <= 1'b1;
            end else if (i_ack) begin
                r_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_seq.sv
// rtl/vector_seq.sv - pc front-end arbitrating decoder requests against RST/NMI/BRK/IRQ vector fetches
// Optional read timeout with fallback load is enabled by defining VEC_TIMEOUT_EN.
module vector_seq
    import vector_seq_pkg::*;
#(
    parameter logic [15:0] RST_VEC = DEF_RST_VEC,
    parameter logic [15:0] NMI_VEC = DEF_NMI_VEC,
    parameter logic [15:0] IRQ_VEC = DEF_IRQ_VEC
`ifdef VEC_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC   = 15,
    parameter logic [15:0] FALLBACK_ADDR = DEF_FALLBACK
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_req,
    input  logic        irq_req,
    input  logic        irq_mask,
    input  logic        brk_req,
    input  logic        fetch_inc,
    input  logic        jump_req,
    input  logic [15:0] jump_add,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        pc_branch,
    output logic        pc_increment,
    output logic [15:0] pc_bra_add,
    output logic        busy,
    output logic [1:0]  vec_src,
    output logic        int_ack,
    output logic        vec_err
);

    state_t      r_state;
    logic [15:0] r_base;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [1:0]  r_src;
    logic        r_rst_pend;
    logic        r_brk_pend;

    logic        w_nmi_pend;
    logic        w_brk_pend;
    logic        w_evt;
    logic [1:0]  w_evt_src;
    logic [15:0] w_evt_base;
    logic        w_take;
    logic        w_nmi_ack;
    logic        w_brk_ack;
    logic [15:0] w_load_addr;

    nmi_edge_latch u_nmi (
        .clk       (clk),
        .rst       (rst),
        .i_nmi_req (nmi_req),
        .i_ack     (w_nmi_ack),
        .o_pend    (w_nmi_pend)
    );

    assign w_brk_pend = r_brk_pend | brk_req;

    always_comb begin
        w_evt      = 1'b0;
        w_evt_src  = VSRC_RST;
        w_evt_base = RST_VEC;
        if (r_rst_pend) begin
            w_evt = 1'b1;
        end else if (w_nmi_pend) begin
            w_evt      = 1'b1;
            w_evt_src  = VSRC_NMI;
            w_evt_base = NMI_VEC;
        end else if (w_brk_pend) begin
            w_evt      = 1'b1;
            w_evt_src  = VSRC_BRK;
            w_evt_base = IRQ_VEC;
        end else if (irq_req && !irq_mask) begin
            w_evt      = 1'b1;
            w_evt_src  = VSRC_IRQ;
            w_evt_base = IRQ_VEC;
        end
    end

    // Pending flags are consumed when the sequence starts, so edges during it stay pending.
    assign w_take    = (r_state == ST_IDLE) && w_evt;
    assign w_nmi_ack = w_take && (w_evt_src == VSRC_NMI);
    assign w_brk_ack = w_take && (w_evt_src == VSRC_BRK);

`ifdef VEC_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC < 16) ? 4 : $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic          w_timeout;

    assign w_timeout   = !mem_ready && (r_wait_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_load_addr = r_timeout ? FALLBACK_ADDR : {r_hi, r_lo};
    assign vec_err     = (r_state == ST_LOAD) && r_timeout;
`else
    assign w_load_addr = {r_hi, r_lo};
    assign vec_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_START;
            r_base     <= 16'h0000;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_src      <= VSRC_RST;
            r_rst_pend <= 1'b1;
            r_brk_pend <= 1'b0;
`ifdef VEC_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_brk_pend <= w_brk_pend & ~w_brk_ack;
            case (r_state)
                ST_START: begin
                    r_state <= ST_FETCH_LO;
                    r_base  <= RST_VEC;
                    r_src   <= VSRC_RST;
`ifdef VEC_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_IDLE: begin
                    if (w_evt) begin
                        r_state <= ST_FETCH_LO;
                        r_base  <= w_evt_base;
                        r_src   <= w_evt_src;
`ifdef VEC_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ready) begin
                        r_lo    <= mem_rdata;
                        r_state <= ST_FETCH_HI;
`ifdef VEC_TIMEOUT_EN
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state   <= ST_LOAD;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
`endif
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        r_hi    <= mem_rdata;
                        r_state <= ST_LOAD;
`ifdef VEC_TIMEOUT_EN
                    end else if (w_timeout) begin
                        r_state   <= ST_LOAD;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
`endif
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_IDLE;
                    if (r_src == VSRC_RST) begin
                        r_rst_pend <= 1'b0;
                    end
`ifdef VEC_TIMEOUT_EN
                    r_timeout <= 1'b0;
`endif
                end
                default: r_state <= ST_START;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign vec_src = r_src;

    always_comb begin
        mem_rd       = 1'b0;
        mem_addr     = 16'h0000;
        pc_branch    = 1'b0;
        pc_increment = 1'b0;
        pc_bra_add   = 16'h0000;
        int_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_evt) begin
                    if (jump_req) begin
                        pc_branch  = 1'b1;
                        pc_bra_add = jump_add;
                    end else if (fetch_inc) begin
                        pc_increment = 1'b1;
                    end
                end
            end
            ST_FETCH_LO: begin
                mem_rd   = 1'b1;
                mem_addr = r_base;
            end
            ST_FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = r_base + 16'd1;
            end
            ST_LOAD: begin
                pc_branch  = 1'b1;
                pc_bra_add = w_load_addr;
                int_ack    = (r_src != VSRC_RST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vector_seq.sv
// tb/tb_vector_seq.sv - directed self-checking bench for vector_seq
module tb_vector_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        nmi_req, irq_req, irq_mask, brk_req;
    logic        fetch_inc, jump_req;
    logic [15:0] jump_add;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        pc_branch, pc_increment;
    logic [15:0] pc_bra_add;
    logic        busy;
    logic [1:0]  vec_src;
    logic        int_ack, vec_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vector_seq dut (
        .clk          (clk),
        .rst          (rst),
        .nmi_req      (nmi_req),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .brk_req      (brk_req),
        .fetch_inc    (fetch_inc),
        .jump_req     (jump_req),
        .jump_add     (jump_add),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .pc_branch    (pc_branch),
        .pc_increment (pc_increment),
        .pc_bra_add   (pc_bra_add),
        .busy         (busy),
        .vec_src      (vec_src),
        .int_ack      (int_ack),
        .vec_err      (vec_err)
    );

    // Vector table: RST=1234, NMI=9000, IRQ/BRK=8000.
    function automatic logic [7:0] vec_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h00;
            16'hFFFB: return 8'h90;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h80;
            default:  return 8'hEE;
        endcase
    endfunction

    assign mem_rdata = vec_byte(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; nmi_req = 1'b0; irq_req = 1'b0; irq_mask = 1'b0; brk_req = 1'b0;
        fetch_inc = 1'b0; jump_req = 1'b0; jump_add = 16'h0000; mem_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_branch", pc_branch, 0);
        check("rst_vec_src", vec_src, 0);
        check("rst_int_ack", int_ack, 0);
        check("rst_vec_err", vec_err, 0);
        rst = 1'b0;
        check("start_busy", busy, 1);
        check("start_mem_rd", mem_rd, 0);

        // Reset vector fetch
        tick();
        check("rv_lo_rd", mem_rd, 1);
        check("rv_lo_addr", mem_addr, 16'hFFFC);
        tick();
        check("rv_hi_addr", mem_addr, 16'hFFFD);
        tick();
        check("rv_load_branch", pc_branch, 1);
        check("rv_load_add", pc_bra_add, 16'h1234);
        check("rv_load_ack", int_ack, 0);
        check("rv_load_busy", busy, 1);
        tick();
        check("rv_idle_busy", busy, 0);
        check("rv_idle_branch", pc_branch, 0);

        // Jump beats increment
        fetch_inc = 1'b1; jump_req = 1'b1; jump_add = 16'hC000;
        #1;
        check("jmp_branch", pc_branch, 1);
        check("jmp_add", pc_bra_add, 16'hC000);
        check("jmp_inc", pc_increment, 0);
        jump_req = 1'b0;
        #1;
        check("inc_only", pc_increment, 1);
        check("inc_no_branch", pc_branch, 0);

        // NMI and IRQ together; NMI first, event suppresses increment
        irq_req = 1'b1; nmi_req = 1'b1;
        #1;
        check("evt_inc_suppressed", pc_increment, 0);
        tick();
        fetch_inc = 1'b0;
        check("nmi_lo_addr", mem_addr, 16'hFFFA);
        check("nmi_src", vec_src, 1);
        tick();
        check("nmi_hi_addr", mem_addr, 16'hFFFB);
        tick();
        check("nmi_load_add", pc_bra_add, 16'h9000);
        check("nmi_ack", int_ack, 1);
        tick();
        nmi_req = 1'b0;
        check("irq_idle_busy", busy, 0);
        tick();
        check("irq_lo_addr", mem_addr, 16'hFFFE);
        check("irq_src", vec_src, 2);
        irq_req = 1'b0;

        // Stall in FETCH_HI
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", mem_addr, 16'hFFFF);
            check("stall_busy", busy, 1);
            check("stall_branch", pc_branch, 0);
            tick();
        end
        mem_ready = 1'b1;
        check("stall_end_addr", mem_addr, 16'hFFFF);
        tick();
        check("irq_load_add", pc_bra_add, 16'h8000);
        check("irq_ack", int_ack, 1);
        check("irq_vec_err", vec_err, 0);
        tick();
        check("irq_done_busy", busy, 0);

        // BRK with an NMI edge arriving mid-sequence
        brk_req = 1'b1;
        tick();
        brk_req = 1'b0;
        check("brk_src", vec_src, 3);
        check("brk_lo_addr", mem_addr, 16'hFFFE);
        nmi_req = 1'b1;
        tick();
        tick();
        check("brk_load_add", pc_bra_add, 16'h8000);
        check("brk_ack", int_ack, 1);
        tick();
        check("late_nmi_idle", busy, 0);
        tick();
        check("late_nmi_addr", mem_addr, 16'hFFFA);
        check("late_nmi_src", vec_src, 1);
        tick();
        tick();
        check("late_nmi_add", pc_bra_add, 16'h9000);
        tick();
        tick();
        check("nmi_level_no_retrigger", busy, 0);
        nmi_req = 1'b0;

        // Reset during FETCH_HI of an IRQ
        irq_req = 1'b1;
        tick();
        tick();
        check("abort_in_hi", mem_addr, 16'hFFFF);
        irq_req = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1);
        check("abort_rd", mem_rd, 0);
        check("abort_src", vec_src, 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_restart_addr", mem_addr, 16'hFFFC);
        tick();
        tick();
        check("abort_load_add", pc_bra_add, 16'h1234);
        check("abort_no_ack", int_ack, 0);
        tick();

`ifdef VEC_TIMEOUT_EN
        brk_req = 1'b1;
        tick();
        brk_req = 1'b0;
        mem_ready = 1'b0;
        repeat (15) tick();
        check("to_branch", pc_branch, 1);
        check("to_add", pc_bra_add, 16'hFFCA);
        check("to_err", vec_err, 1);
        mem_ready = 1'b1;
        tick();
        check("to_err_clear", vec_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
